alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals shared by the arbiter and its environment.
// slave is the arbiter's view; master is the view of the requesters plus ALU.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [1:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [1:0] req1_op;
  logic [7:0] alu_inreg1;
  logic [7:0] alu_inreg2;
  logic [1:0] alu_opcode;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result,
    output req0_ready, req1_ready,
    output alu_inreg1, alu_inreg2, alu_opcode,
    output rsp_valid, rsp_id, rsp_data, busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result,
    input  req0_ready, req1_ready,
    input  alu_inreg1, alu_inreg2, alu_opcode,
    input  rsp_valid, rsp_id, rsp_data, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// A granted operation is held on the ALU ports for ALU_LAT cycles, then answered by a one-cycle pulse.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

  state_t     r_state;
  logic       r_ptr;
  logic [2:0] r_cnt;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [1:0] r_op;
  logic       r_id;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [7:0] r_rsp_data;
  logic [7:0] r_op_count;

  logic [1:0] w_valid;
  logic [1:0] w_ready;
  logic       w_grant;
  logic       w_xfer;
  logic [7:0] w_sel_a;
  logic [7:0] w_sel_b;
  logic [1:0] w_sel_op;

  assign w_valid = {bus.req1_valid, bus.req0_valid};
  // Pointer only matters when both compete; a lone requester always wins.
  assign w_grant = (w_valid == 2'b11) ? r_ptr : w_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign w_ready[gi] = (r_state == IDLE) && w_valid[gi] && (w_grant == 1'(gi));
    end
  endgenerate

  assign w_xfer   = |w_ready;
  assign w_sel_a  = w_grant ? bus.req1_a  : bus.req0_a;
  assign w_sel_b  = w_grant ? bus.req1_b  : bus.req0_b;
  assign w_sel_op = w_grant ? bus.req1_op : bus.req0_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_cnt       <= 3'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_op        <= 2'd0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_op_count  <= 8'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_id    <= w_grant;
            r_ptr   <= ~w_grant;
            r_cnt   <= LAT_LOAD;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt == 3'd1) begin
            r_rsp_data  <= bus.alu_result;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_op_count  <= r_op_count + 8'd1;
            r_state     <= RESP;
          end
          r_cnt <= r_cnt - 3'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.alu_inreg1 = r_a;
  assign bus.alu_inreg2 = r_b;
  assign bus.alu_opcode = r_op;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.busy       = (r_state != IDLE);
  assign bus.op_count   = r_op_count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance with ALU_LAT=1 and one with ALU_LAT=3, each checked every
// cycle against a timestamp model of the arbitration rules, plus directed literal expectations.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   checks = 0;
  int   failures = 0;
  int   ecount = 0;

  alu_arbiter_if if1();
  alu_arbiter_if if3();

  alu_arbiter #(.ALU_LAT(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  alu_arbiter #(.ALU_LAT(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign if1.alu_result = alu_f(if1.alu_inreg1, if1.alu_inreg2, if1.alu_opcode);
  assign if3.alu_result = alu_f(if3.alu_inreg1, if3.alu_inreg2, if3.alu_opcode);

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Timestamp model: cycle k lies between edges k and k+1 counted from reset release.
  int         m_cyc[2], m_free[2], m_pend_at[2], m_rsp_at[2];
  bit         m_ptr[2], m_pend_id[2], m_rsp_id[2];
  logic [7:0] m_in1[2], m_in2[2], m_pend_data[2], m_rsp_data[2], m_count[2];
  logic [1:0] m_opc[2];

  task automatic model_reset(int d);
    m_cyc[d] = 0; m_free[d] = 0; m_pend_at[d] = -1; m_rsp_at[d] = -1;
    m_ptr[d] = 0; m_pend_id[d] = 0; m_rsp_id[d] = 0;
    m_in1[d] = 0; m_in2[d] = 0; m_opc[d] = 0;
    m_pend_data[d] = 0; m_rsp_data[d] = 0; m_count[d] = 0;
  endtask

  task automatic model_step(int d, bit r, bit v0, bit v1, logic [7:0] a0, logic [7:0] b0,
                            logic [1:0] op0, logic [7:0] a1, logic [7:0] b1, logic [1:0] op1);
    int L;
    bit g;
    L = (d == 0) ? 1 : 3;
    if (r) begin
      model_reset(d);
      return;
    end
    if (m_cyc[d] >= m_free[d] && (v0 || v1)) begin
      g = (v0 && v1) ? m_ptr[d] : v1;
      m_in1[d] = g ? a1 : a0;
      m_in2[d] = g ? b1 : b0;
      m_opc[d] = g ? op1 : op0;
      m_pend_id[d] = g;
      m_pend_data[d] = alu_f(m_in1[d], m_in2[d], m_opc[d]);
      m_pend_at[d] = m_cyc[d] + 1 + L;
      m_free[d] = m_cyc[d] + 2 + L;
      m_ptr[d] = !g;
    end
    m_cyc[d]++;
    if (m_cyc[d] == m_pend_at[d]) begin
      m_rsp_id[d] = m_pend_id[d];
      m_rsp_data[d] = m_pend_data[d];
      m_count[d] = m_count[d] + 8'd1;
      m_rsp_at[d] = m_cyc[d];
    end
  endtask

  initial begin
    model_reset(0);
    forever begin
      @(posedge clk or posedge rst1);
      model_step(0, rst1, if1.req0_valid, if1.req1_valid, if1.req0_a, if1.req0_b, if1.req0_op,
                 if1.req1_a, if1.req1_b, if1.req1_op);
    end
  end

  initial begin
    model_reset(1);
    forever begin
      @(posedge clk or posedge rst3);
      model_step(1, rst3, if3.req0_valid, if3.req1_valid, if3.req0_a, if3.req0_b, if3.req0_op,
                 if3.req1_a, if3.req1_b, if3.req1_op);
    end
  end

  task automatic compare(int d, bit v0, bit v1, bit r0, bit r1, logic [7:0] i1, logic [7:0] i2,
                         logic [1:0] opc, bit rv, bit rid, logic [7:0] rd, bit bsy, logic [7:0] cnt);
    bit idle, g;
    idle = (m_cyc[d] >= m_free[d]);
    g = (v0 && v1) ? m_ptr[d] : v1;
    chk($sformatf("d%0d_req0_ready", d), r0, idle && v0 && !g);
    chk($sformatf("d%0d_req1_ready", d), r1, idle && v1 && g);
    chk($sformatf("d%0d_alu_inreg1", d), i1, m_in1[d]);
    chk($sformatf("d%0d_alu_inreg2", d), i2, m_in2[d]);
    chk($sformatf("d%0d_alu_opcode", d), opc, m_opc[d]);
    chk($sformatf("d%0d_rsp_valid", d), rv, m_cyc[d] == m_rsp_at[d]);
    chk($sformatf("d%0d_rsp_id", d), rid, m_rsp_id[d]);
    chk($sformatf("d%0d_rsp_data", d), rd, m_rsp_data[d]);
    chk($sformatf("d%0d_busy", d), bsy, !idle);
    chk($sformatf("d%0d_op_count", d), cnt, m_count[d]);
  endtask

  initial forever begin
    @(negedge clk);
    compare(0, if1.req0_valid, if1.req1_valid, if1.req0_ready, if1.req1_ready, if1.alu_inreg1,
            if1.alu_inreg2, if1.alu_opcode, if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.busy,
            if1.op_count);
    compare(1, if3.req0_valid, if3.req1_valid, if3.req0_ready, if3.req1_ready, if3.alu_inreg1,
            if3.alu_inreg2, if3.alu_opcode, if3.rsp_valid, if3.rsp_id, if3.rsp_data, if3.busy,
            if3.op_count);
  end

  // Observed transfers (edge they occur on) and responses (edge that opens the pulse cycle).
  int g1_id[$], g1_e[$], r1_id[$], r1_e[$];
  int g3_id[$], g3_e[$], r3_id[$], r3_e[$];

  initial forever begin
    @(negedge clk);
    if (if1.req0_valid && if1.req0_ready) begin g1_id.push_back(0); g1_e.push_back(ecount + 1); end
    if (if1.req1_valid && if1.req1_ready) begin g1_id.push_back(1); g1_e.push_back(ecount + 1); end
    if (if1.rsp_valid) begin r1_id.push_back(int'(if1.rsp_id)); r1_e.push_back(ecount); end
    if (if3.req0_valid && if3.req0_ready) begin g3_id.push_back(0); g3_e.push_back(ecount + 1); end
    if (if3.req1_valid && if3.req1_ready) begin g3_id.push_back(1); g3_e.push_back(ecount + 1); end
    if (if3.rsp_valid) begin r3_id.push_back(int'(if3.rsp_id)); r3_e.push_back(ecount); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int d, int r, bit v, logic [7:0] a, logic [7:0] b, logic [1:0] op);
    if (d == 0 && r == 0) begin if1.req0_valid = v; if1.req0_a = a; if1.req0_b = b; if1.req0_op = op; end
    if (d == 0 && r == 1) begin if1.req1_valid = v; if1.req1_a = a; if1.req1_b = b; if1.req1_op = op; end
    if (d == 1 && r == 0) begin if3.req0_valid = v; if3.req0_a = a; if3.req0_b = b; if3.req0_op = op; end
    if (d == 1 && r == 1) begin if3.req1_valid = v; if3.req1_a = a; if3.req1_b = b; if3.req1_op = op; end
  endtask

  task automatic do_op1(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    int k;
    k = 0;
    set_req(0, 0, 1'b1, a, b, op);
    #1;
    while (!if1.req0_ready && k < 8) begin
      tick();
      k++;
    end
    chk("op_grant_wait", if1.req0_ready, 1);
    tick();
    set_req(0, 0, 1'b0, 8'd0, 8'd0, 2'd0);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t0, bcnt, n;
    bit done;
    logic [7:0] s3_data;
    rst1 = 1'b1;
    rst3 = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) set_req(d, r, 1'b0, 8'd0, 8'd0, 2'd0);
    repeat (2) tick();
    chk("rst_op_count1", if1.op_count, 0);
    chk("rst_busy3", if3.busy, 0);
    chk("rst_rsp_data1", if1.rsp_data, 0);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // Single op on the ALU_LAT=1 instance
    set_req(0, 0, 1'b1, 8'd8, 8'd5, 2'd0);
    #1;
    chk("s1_req0_ready", if1.req0_ready, 1);
    tick();
    set_req(0, 0, 1'b0, 8'd0, 8'd0, 2'd0);
    #1;
    chk("s1_inreg1", if1.alu_inreg1, 8);
    chk("s1_inreg2", if1.alu_inreg2, 5);
    chk("s1_ready_after", if1.req0_ready, 0);
    chk("s1_rsp_early", if1.rsp_valid, 0);
    tick();
    chk("s1_rsp_valid", if1.rsp_valid, 1);
    chk("s1_rsp_id", if1.rsp_id, 0);
    chk("s1_rsp_data", if1.rsp_data, 13);
    chk("s1_op_count", if1.op_count, 1);
    tick();
    chk("s1_rsp_pulse_end", if1.rsp_valid, 0);
    chk("s1_rsp_data_hold", if1.rsp_data, 13);
    chk("s1_inreg1_hold", if1.alu_inreg1, 8);

    // Contention from reset with both requesters held valid
    rst1 = 1'b1;
    set_req(0, 0, 1'b1, 8'd10, 8'd1, 2'd0);
    set_req(0, 1, 1'b1, 8'd20, 8'd2, 2'd1);
    tick();
    rst1 = 1'b0;
    g1_id.delete(); g1_e.delete(); r1_id.delete(); r1_e.delete();
    repeat (12) tick();
    set_req(0, 0, 1'b0, 8'd0, 8'd0, 2'd0);
    set_req(0, 1, 1'b0, 8'd0, 8'd0, 2'd0);
    if (g1_id.size() < 4 || r1_id.size() < 4) begin
      chk("s2_grant_count", g1_id.size(), 4);
      chk("s2_rsp_count", r1_id.size(), 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("s2_grant%0d", i), g1_id[i], i % 2);
        chk($sformatf("s2_rsp_id%0d", i), r1_id[i], i % 2);
        chk($sformatf("s2_rsp_lat%0d", i), r1_e[i] - g1_e[i], 1);
      end
    end
    repeat (2) tick();

    // Latency 3 with req1 held valid across the operation
    n = g3_id.size();
    set_req(1, 1, 1'b1, 8'd20, 8'd7, 2'd1);
    #1;
    chk("s3_req1_ready", if3.req1_ready, 1);
    tick();
    t0 = ecount;
    bcnt = 0;
    done = 1'b0;
    s3_data = 8'd0;
    for (int k = 0; k < 10 && !done; k++) begin
      if (if3.busy) begin
        bcnt++;
        if (if3.rsp_valid) s3_data = if3.rsp_data;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    chk("s3_busy_cycles", bcnt, 4);
    chk("s3_rsp_data", s3_data, 13);
    chk("s3_ready_edge", ecount - t0, 4);
    chk("s3_ready_again", if3.req1_ready, 1);
    tick();
    set_req(1, 1, 1'b0, 8'd0, 8'd0, 2'd0);
    if (r3_id.size() <= n || g3_id.size() <= n) begin
      chk("s3_rsp_count", r3_id.size(), n + 1);
    end else begin
      chk("s3_rsp_lat", r3_e[n] - g3_e[n], 3);
      chk("s3_rsp_id", r3_id[n], 1);
    end
    repeat (5) tick();

    // Reset one cycle into EXEC discards the operation
    set_req(1, 0, 1'b1, 8'd3, 8'd4, 2'd3);
    #1;
    tick();
    set_req(1, 0, 1'b0, 8'd0, 8'd0, 2'd0);
    tick();
    rst3 = 1'b1;
    #1;
    n = r3_id.size();
    chk("s4_busy", if3.busy, 0);
    chk("s4_inreg1", if3.alu_inreg1, 0);
    chk("s4_inreg2", if3.alu_inreg2, 0);
    chk("s4_opcode", if3.alu_opcode, 0);
    chk("s4_rsp_valid", if3.rsp_valid, 0);
    chk("s4_rsp_id", if3.rsp_id, 0);
    chk("s4_rsp_data", if3.rsp_data, 0);
    chk("s4_op_count", if3.op_count, 0);
    repeat (2) tick();
    rst3 = 1'b0;
    repeat (6) tick();
    chk("s4_no_rsp_after", r3_id.size(), n);
    chk("s4_op_count_after", if3.op_count, 0);

    // op_count wrap over 256 operations, then ignored valid during EXEC
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    for (int i = 0; i < 255; i++) do_op1(8'(i), 8'(i * 3), 2'(i));
    tick();
    chk("s5_count_255", if1.op_count, 255);
    do_op1(8'd200, 8'd100, 2'd0);
    tick();
    chk("s5_count_wrap", if1.op_count, 0);
    tick();
    do_op1(8'd1, 8'd2, 2'd0);
    set_req(0, 1, 1'b1, 8'd9, 8'd9, 2'd2);
    #1;
    chk("s5_ign_exec", if1.req1_ready, 0);
    tick();
    chk("s5_ign_resp", if1.req1_ready, 0);
    chk("s5_resp_pulse", if1.rsp_valid, 1);
    tick();
    chk("s5_req1_idle", if1.req1_ready, 1);
    tick();
    set_req(0, 1, 1'b0, 8'd0, 8'd0, 2'd0);
    repeat (4) tick();
    chk("s5_final_count", if1.op_count, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
